// File: rtl/tristate_bus_arbiter_pkg.sv
// rtl/tristate_bus_arbiter_pkg.sv - state encoding and shared defaults for the tristate bus arbiter
package tristate_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int GAP_CNT_WIDTH      = 3;

endpackage

// File: rtl/tristate_bus_arbiter_rr.sv
// rtl/tristate_bus_arbiter_rr.sv - combinational round-robin search from a pointer with a mask
module rr_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic [NUM_SOURCES-1:0] i_req,
  input  logic [NUM_SOURCES-1:0] i_mask,
  input  logic [ID_WIDTH-1:0]    i_ptr,
  output logic [NUM_SOURCES-1:0] o_grant,
  output logic [ID_WIDTH-1:0]    o_idx,
  output logic                   o_valid
);

  localparam int PW = ID_WIDTH + 1;

  logic [NUM_SOURCES-1:0] w_eligible;
  logic [PW-1:0]          w_pos;

  assign w_eligible = i_req & ~i_mask;

  // Walk upward from the pointer; the first eligible slot wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      w_pos = PW'(i_ptr) + PW'(k);
      if (w_pos >= PW'(NUM_SOURCES)) begin
        w_pos = w_pos - PW'(NUM_SOURCES);
      end
      if (!o_valid && w_eligible[w_pos[ID_WIDTH-1:0]]) begin
        o_valid                        = 1'b1;
        o_idx                          = w_pos[ID_WIDTH-1:0];
        o_grant[w_pos[ID_WIDTH-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// rtl/tristate_bus_arbiter.sv - round-robin multi-source tristate bus driver with turnaround gap
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int NUM_SOURCES       = 4,
  parameter int ID_WIDTH          = 2,
  parameter int TURNAROUND_CYCLES = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SOURCES-1:0]          req,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] req_data,
  input  logic                            bus_inhibit,
  output logic [NUM_SOURCES-1:0]          ack,
  output logic [DATA_WIDTH-1:0]           bus_data,
  output logic                            bus_valid,
  output logic [ID_WIDTH-1:0]             grant_id,
  output logic                            busy
);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [ID_WIDTH-1:0]      r_grant_id;
  logic [ID_WIDTH-1:0]      r_ptr;
  logic [GAP_CNT_WIDTH-1:0] r_gap_cnt;

  logic [NUM_SOURCES-1:0]   w_owner_oh;
  logic [NUM_SOURCES-1:0]   w_mask;
  logic [NUM_SOURCES-1:0]   w_arb_grant;
  logic [ID_WIDTH-1:0]      w_arb_idx;
  logic                     w_arb_valid;
  logic                     w_can_grant;
  logic                     w_take;
  logic [DATA_WIDTH-1:0]    w_sel_data;

  assign w_owner_oh  = {{(NUM_SOURCES-1){1'b0}}, 1'b1} << r_grant_id;
  // Only relevant for zero-turnaround: the owner's req is still high at its exit edge.
  assign w_mask      = (r_state == ST_DRIVE) ? w_owner_oh : '0;
  assign w_can_grant = !bus_inhibit && w_arb_valid;

  rr_arbiter #(
    .NUM_SOURCES (NUM_SOURCES),
    .ID_WIDTH    (ID_WIDTH)
  ) u_rr (
    .i_req   (req),
    .i_mask  (w_mask),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (w_arb_grant[i]) begin
        w_sel_data = w_sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_can_grant) begin
          w_state_nxt = ST_DRIVE;
          w_take      = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (TURNAROUND_CYCLES != 0) begin
          w_state_nxt = ST_GAP;
        end else if (w_can_grant) begin
          w_state_nxt = ST_DRIVE;
          w_take      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt <= GAP_CNT_WIDTH'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_data     <= w_sel_data;
        r_grant_id <= w_arb_idx;
        r_ptr      <= (w_arb_idx == ID_WIDTH'(NUM_SOURCES-1)) ? '0 : w_arb_idx + 1'b1;
      end
      if (r_state == ST_DRIVE) begin
        r_gap_cnt <= GAP_CNT_WIDTH'(TURNAROUND_CYCLES);
      end else if (r_state == ST_GAP) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  assign bus_valid = (r_state == ST_DRIVE);
  assign ack       = bus_valid ? w_owner_oh : '0;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = r_grant_id;
  assign bus_data  = bus_valid ? r_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb/tb_tristate_bus_arbiter.sv - directed scoreboard bench for tristate_bus_arbiter (turnaround 1 and 0)
module tb_tristate_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   a_req, b_req;
  logic [127:0] a_data, b_data;
  logic         a_inh, b_inh;
  logic [3:0]   a_ack, b_ack;
  wire  [31:0]  a_bus, b_bus;
  logic         a_valid, b_valid, a_busy, b_busy;
  logic [1:0]   a_gid, b_gid;

  tristate_bus_arbiter #(.DATA_WIDTH(32), .NUM_SOURCES(4), .ID_WIDTH(2), .TURNAROUND_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req(a_req), .req_data(a_data), .bus_inhibit(a_inh),
    .ack(a_ack), .bus_data(a_bus), .bus_valid(a_valid), .grant_id(a_gid), .busy(a_busy)
  );

  tristate_bus_arbiter #(.DATA_WIDTH(32), .NUM_SOURCES(4), .ID_WIDTH(2), .TURNAROUND_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .req_data(b_data), .bus_inhibit(b_inh),
    .ack(b_ack), .bus_data(b_bus), .bus_valid(b_valid), .grant_id(b_gid), .busy(b_busy)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_drive(input bit use_b, input string tag);
    exp_t        e;
    logic [3:0]  oh;
    logic        v;
    logic [1:0]  g;
    logic [3:0]  k;
    logic [31:0] d;
    logic        y;
    v = use_b ? b_valid : a_valid;
    g = use_b ? b_gid   : a_gid;
    k = use_b ? b_ack   : a_ack;
    d = use_b ? b_bus   : a_bus;
    y = use_b ? b_busy  : a_busy;
    chk({tag, "_valid"}, 64'(v), 64'(1'b1));
    chk({tag, "_busy"}, 64'(y), 64'(1'b1));
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1'b1));
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      oh = 4'b0001 << e.id;
      chk({tag, "_grant_id"}, 64'(g), 64'(e.id));
      chk({tag, "_data"}, 64'(d), 64'(e.data));
      chk({tag, "_ack"}, 64'(k), 64'(oh));
    end
  endtask

  task automatic check_idle(input bit use_b, input string tag, input logic exp_busy);
    logic [31:0] zz;
    zz = {32{1'bz}};
    chk({tag, "_valid"}, 64'(use_b ? b_valid : a_valid), 64'(1'b0));
    chk({tag, "_ack"}, 64'(use_b ? b_ack : a_ack), 64'(4'b0000));
    chk({tag, "_bus_z"}, 64'(use_b ? b_bus : a_bus), 64'(zz));
    chk({tag, "_busy"}, 64'(use_b ? b_busy : a_busy), 64'(exp_busy));
  endtask

  initial begin
    rst_n  = 1'b0;
    a_req  = '0;
    b_req  = '0;
    a_data = '0;
    b_data = '0;
    a_inh  = 1'b0;
    b_inh  = 1'b0;
    repeat (2) @(negedge clk);
    check_idle(0, "rst_a", 1'b0);
    check_idle(1, "rst_b", 1'b0);
    chk("rst_a_gid", 64'(a_gid), 64'(2'd0));

    // Single request from source 2.
    rst_n = 1'b1;
    a_req = 4'b0100;
    a_data[2*32 +: 32] = 32'hDEADBEEF;
    push(2'd2, 32'hDEADBEEF);
    @(negedge clk); check_drive(0, "single");
    a_req = 4'b0000;
    @(negedge clk); check_idle(0, "single_gap", 1'b1);
    @(negedge clk); check_idle(0, "single_idle", 1'b0);

    // Pointer now 3: source 3 beats source 0, then wraps to 0.
    a_req = 4'b1001;
    a_data[3*32 +: 32] = 32'h3333_0003;
    a_data[0*32 +: 32] = 32'h0000_0A00;
    push(2'd3, 32'h3333_0003);
    push(2'd0, 32'h0000_0A00);
    @(negedge clk); check_drive(0, "wrap3");
    a_req = 4'b0001;
    @(negedge clk); check_idle(0, "wrap_gap", 1'b1);
    @(negedge clk); check_idle(0, "wrap_idle", 1'b0);
    @(negedge clk); check_drive(0, "wrap0");
    a_req = 4'b0000;
    @(negedge clk); check_idle(0, "wrap_gap2", 1'b1);

    // Fresh reset, all four request together.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      a_data[i*32 +: 32] = 32'hA0A0_0000 + 32'(i);
      push(2'(i), 32'hA0A0_0000 + 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check_drive(0, "rr_drive");
      a_req[i] = 1'b0;
      @(negedge clk); check_idle(0, "rr_gap", 1'b1);
      @(negedge clk); check_idle(0, "rr_idle", 1'b0);
    end

    // Inhibit holds off source 3 until released.
    a_inh = 1'b1;
    a_req = 4'b1000;
    a_data[3*32 +: 32] = 32'hC0FF_EE03;
    repeat (5) begin
      @(negedge clk); check_idle(0, "inhibit", 1'b0);
    end
    a_inh = 1'b0;
    push(2'd3, 32'hC0FF_EE03);
    @(negedge clk); check_drive(0, "inhibit_release");
    a_req = 4'b0000;
    @(negedge clk); check_idle(0, "inhibit_gap", 1'b1);

    // Zero turnaround: back-to-back, owner masked at its exit edge.
    b_req = 4'b0011;
    b_data[0*32 +: 32] = 32'hB000_0000;
    b_data[1*32 +: 32] = 32'hB111_1111;
    push(2'd0, 32'hB000_0000);
    push(2'd1, 32'hB111_1111);
    @(negedge clk); check_drive(1, "b2b_src0");
    @(negedge clk); check_drive(1, "b2b_src1");
    b_req = 4'b0010;
    @(negedge clk); check_idle(1, "b2b_end", 1'b0);
    b_req = 4'b0001;
    b_data[0*32 +: 32] = 32'hB0B0_5A5A;
    push(2'd0, 32'hB0B0_5A5A);
    @(negedge clk); check_drive(1, "mask_src0");
    @(negedge clk); check_idle(1, "mask_no_regrant", 1'b0);
    b_req = 4'b0000;

    // Reset during DRIVE aborts; held req is re-granted with freshly sampled data.
    a_req = 4'b0010;
    a_data[1*32 +: 32] = 32'h1111_1111;
    push(2'd1, 32'h1111_1111);
    @(negedge clk); check_drive(0, "pre_reset");
    rst_n = 1'b0;
    a_data[1*32 +: 32] = 32'h2222_2222;
    @(negedge clk); check_idle(0, "reset_abort", 1'b0);
    chk("reset_abort_gid", 64'(a_gid), 64'(2'd0));
    rst_n = 1'b1;
    push(2'd1, 32'h2222_2222);
    @(negedge clk); check_drive(0, "post_reset");
    a_req = 4'b0000;
    @(negedge clk); check_idle(0, "post_reset_gap", 1'b1);

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
